// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states, baud-counter sizing
// and the 2-of-3 vote used by majority sampling.
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PAR      = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int baud_cnt_w(input int clk_freq, input int uart_bps);
    return $clog2(clk_freq / uart_bps);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter with three sample taps (mid-2, mid, mid+2) around the bit mid-point.
// Held at zero while clr is high; shared by receiver and future transmitter.
module uart_baud_tick #(
  parameter int CNT_MAX = 5208,
  parameter int CNT_W   = 13
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick_early,
  output logic tick_mid,
  output logic tick_late
);

  localparam int               MID       = CNT_MAX / 2 - 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(MID - 2);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(MID + 2);

  logic [CNT_W-1:0] cnt_r;

  // Free-running bit-period counter, wrapping at the end of each bit
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign tick_early = en && (cnt_r == CNT_EARLY);
  assign tick_mid   = en && (cnt_r == CNT_MID);
  assign tick_late  = en && (cnt_r == CNT_LATE);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits) reporting parity, framing and break.
// Build option UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of samples at mid-2, mid, mid+2.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int             BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int             CNT_W        = baud_cnt_w(CLK_FREQ, UART_BPS);
  localparam int             BIT_W        = 4;
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic           PAR_EXP      = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

  logic       rx_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0] sync_fill_r;
  logic       fall_s;

  // Two-flop synchroniser; edge history only tracks rx once the pipeline holds real samples,
  // so a line held low through reset release is never mistaken for a start bit
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b0;
      sync_fill_r <= 2'b00;
    end else begin
      rx_meta_r   <= rx;
      rx_sync_r   <= rx_meta_r;
      sync_fill_r <= {sync_fill_r[0], 1'b1};
      if (sync_fill_r[1]) begin
        rx_prev_r <= rx_sync_r;
      end
    end
  end

  assign fall_s = rx_prev_r & ~rx_sync_r;

  rx_state_e            state_r, state_nxt;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_r, shift_nxt;
  logic                 par_err_r, par_err_nxt;
  logic                 frm_err_r, frm_err_nxt;
  logic                 zero_r, zero_nxt;
  logic                 done_s;
  logic                 cnt_clr_s;
  logic                 tick_early_s, tick_mid_s, tick_late_s;
  logic                 bit_tick_s, bit_val_s;

  assign cnt_clr_s = (state_r == ST_IDLE);

  uart_baud_tick #(
    .CNT_MAX(BAUD_CNT_MAX),
    .CNT_W  (CNT_W)
  ) u_baud_tick (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .en        (~cnt_clr_s),
    .clr       (cnt_clr_s),
    .tick_early(tick_early_s),
    .tick_mid  (tick_mid_s),
    .tick_late (tick_late_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic samp_early_r, samp_mid_r;

  // Capture the two earlier votes; the third is the live sample on the late tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      samp_early_r <= 1'b1;
      samp_mid_r   <= 1'b1;
    end else begin
      if (tick_early_s) begin
        samp_early_r <= rx_sync_r;
      end
      if (tick_mid_s) begin
        samp_mid_r <= rx_sync_r;
      end
    end
  end

  assign bit_tick_s = tick_late_s;
  assign bit_val_s  = maj3(samp_early_r, samp_mid_r, rx_sync_r);
`else
  logic unused_ticks_s;

  assign unused_ticks_s = tick_early_s | tick_late_s;
  assign bit_tick_s     = tick_mid_s;
  assign bit_val_s      = rx_sync_r;
`endif

  // Frame state and per-frame accumulators
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      par_err_r <= par_err_nxt;
      frm_err_r <= frm_err_nxt;
      zero_r    <= zero_nxt;
    end
  end

  // Next-state logic; zero_r stays set only while every sampled bit after start is low
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    par_err_nxt = par_err_r;
    frm_err_nxt = frm_err_r;
    zero_nxt    = zero_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt   = ST_START;
          bit_cnt_nxt = {BIT_W{1'b0}};
          par_err_nxt = 1'b0;
          frm_err_nxt = 1'b0;
          zero_nxt    = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          state_nxt = bit_val_s ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          shift_nxt = {bit_val_s, shift_r[DATA_BITS-1:1]};
          zero_nxt  = zero_r & ~bit_val_s;
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_nxt = {BIT_W{1'b0}};
            state_nxt   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_PAR: begin
        if (bit_tick_s) begin
          par_err_nxt = par_err_r | ((^shift_r ^ bit_val_s) != PAR_EXP);
          zero_nxt    = zero_r & ~bit_val_s;
          state_nxt   = ST_STOP;
        end else begin
          state_nxt = ST_PAR;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          frm_err_nxt = frm_err_r | ~bit_val_s;
          zero_nxt    = zero_r & ~bit_val_s;
          if (bit_cnt_r == STOP_LAST) begin
            done_s    = 1'b1;
            state_nxt = zero_nxt ? ST_BRK_WAIT : ST_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_nxt = ST_STOP;
        end
      end
      ST_BRK_WAIT: begin
        state_nxt = rx_sync_r ? ST_IDLE : ST_BRK_WAIT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Result registers: updated together with the one-cycle po_flag pulse, held otherwise
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_flag    <= 1'b0;
      po_data    <= {DATA_BITS{1'b0}};
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      po_flag <= done_s;
      if (done_s) begin
        po_data    <= shift_r;
        parity_err <= par_err_nxt;
        frame_err  <= frm_err_nxt;
        break_det  <= zero_nxt;
      end
    end
  end

endmodule
